// File: rtl/dmem_responder.sv
// Memory-side responder for the EX/MEM data-request interface: runs one
// dREN/dWEN request at a time against the RAM handshake and returns a dHit pulse.
module dmem_responder #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNTW    = 16,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            dREN,
  input  logic            dWEN,
  input  logic [31:0]     daddr,
  input  logic [31:0]     dstore,
  input  logic            halt,
  output logic            dHit,
  output logic [31:0]     dload,
  output logic            derr,
  output logic            ramREN,
  output logic            ramWEN,
  output logic [31:0]     ramaddr,
  output logic [31:0]     ramstore,
  input  logic [31:0]     ramload,
  input  logic [1:0]      ramstate,
  output logic [CNTW-1:0] rd_count,
  output logic [CNTW-1:0] wr_count
);

  localparam int unsigned   TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]    RS_ACCESS = 2'd2;
  localparam logic [1:0]    RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            dhit_q, dhit_d;
  logic [31:0]     dload_q, dload_d;
  logic            derr_q, derr_d;
  logic            ramren_q, ramren_d;
  logic            ramwen_q, ramwen_d;
  logic [31:0]     ramaddr_q, ramaddr_d;
  logic [31:0]     ramstore_q, ramstore_d;
  logic [CNTW-1:0] rd_count_q, rd_count_d;
  logic [CNTW-1:0] wr_count_q, wr_count_d;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    dhit_d     = 1'b0;
    dload_d    = dload_q;
    derr_d     = derr_q;
    ramren_d   = ramren_q;
    ramwen_d   = ramwen_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE: begin
        if (!halt && (dREN || dWEN)) begin
          if ((dREN && dWEN) || (daddr[1:0] != 2'b00)) begin
            state_d = ERR;
            dhit_d  = 1'b1;
            dload_d = ERRWORD;
            derr_d  = 1'b1;
          end else begin
            state_d    = REQ;
            ramaddr_d  = daddr;
            ramstore_d = dstore;
            ramren_d   = dREN;
            ramwen_d   = dWEN;
            tcnt_d     = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        tcnt_d = tcnt_q + TW'(1);
        // ACCESS is checked first so it beats a timeout expiring in the same cycle
        if (ramstate == RS_ACCESS) begin
          state_d  = RESP;
          dhit_d   = 1'b1;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
          if (ramren_q) begin
            dload_d    = ramload;
            rd_count_d = sat_inc(rd_count_q);
          end else begin
            wr_count_d = sat_inc(wr_count_q);
          end
        end else if ((ramstate == RS_ERROR) || (tcnt_q == TLAST)) begin
          state_d  = ERR;
          dhit_d   = 1'b1;
          dload_d  = ERRWORD;
          derr_d   = 1'b1;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
        end else begin
          state_d = REQ;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: begin
        state_d  = IDLE;
        ramren_d = 1'b0;
        ramwen_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      tcnt_q     <= '0;
      dhit_q     <= 1'b0;
      dload_q    <= 32'h0000_0000;
      derr_q     <= 1'b0;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= 32'h0000_0000;
      ramstore_q <= 32'h0000_0000;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      dhit_q     <= dhit_d;
      dload_q    <= dload_d;
      derr_q     <= derr_d;
      ramren_q   <= ramren_d;
      ramwen_q   <= ramwen_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign dHit     = dhit_q;
  assign dload    = dload_q;
  assign derr     = derr_q;
  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder; outcomes are predicted from
// request legality, wait-state count and timeout rules.
module tb_dmem_responder;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNTW    = 2;
  localparam logic [31:0] ERRWORD = 32'hBAD1BAD1;
  localparam logic [1:0]  RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;
  localparam int K_ACCESS = 0, K_ERROR = 1, K_STUCK = 2;

  logic            CLK = 1'b0;
  logic            RST, dREN, dWEN, halt;
  logic [31:0]     daddr, dstore, ramload;
  logic [1:0]      ramstate;
  logic            dHit, derr, ramREN, ramWEN;
  logic [31:0]     dload, ramaddr, ramstore;
  logic [CNTW-1:0] rd_count, wr_count;

  int checks = 0;
  int failures = 0;
  int exp_rd = 0, exp_wr = 0;
  logic exp_derr = 1'b0;
  logic [31:0] exp_dload = 32'h0;

  dmem_responder #(.TIMEOUT(TIMEOUT), .CNTW(CNTW), .ERRWORD(ERRWORD)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .halt(halt), .dHit(dHit), .dload(dload), .derr(derr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CNTW) - 1) ? (1 << CNTW) - 1 : v + 1;
  endfunction

  // Called at a negedge while the DUT is idle; returns one idle cycle after the hit.
  task automatic run_txn(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] data, input int busy_n, input int kind);
    logic        illegal;
    bit          exp_ok;
    int          exp_en, en_cnt, hit_cyc;
    logic [31:0] load_v;
    illegal = (ren & wen) | (addr[1:0] != 2'b00);
    if (illegal) begin
      exp_en = 0; exp_ok = 0;
    end else if (kind != K_STUCK && busy_n < int'(TIMEOUT)) begin
      exp_en = busy_n + 1; exp_ok = (kind == K_ACCESS);
    end else begin
      exp_en = TIMEOUT; exp_ok = 0;
    end
    load_v = $urandom;
    dREN = ren; dWEN = wen; daddr = addr; dstore = data; ramload = load_v; ramstate = RS_BUSY;
    en_cnt = 0; hit_cyc = 0;
    for (int k = 1; k <= 40 && hit_cyc == 0; k++) begin
      @(negedge CLK);
      if (ramREN | ramWEN) begin
        en_cnt++;
        check("en_excl", {31'd0, ramREN & ramWEN}, 32'd0);
        check("en_dir", {30'd0, ramREN, ramWEN}, {30'd0, ren, wen});
        check("ramaddr", ramaddr, addr);
        check("ramstore", ramstore, data);
      end
      if (dHit) hit_cyc = k;
      else if (k <= busy_n || kind == K_STUCK) ramstate = ($urandom_range(0, 1) == 0) ? RS_BUSY : RS_FREE;
      else ramstate = (kind == K_ACCESS) ? RS_ACCESS : RS_ERROR;
    end
    dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE;
    if (exp_ok) begin
      if (ren) begin exp_rd = sat(exp_rd); exp_dload = load_v; end
      else exp_wr = sat(exp_wr);
    end else begin
      exp_derr = 1'b1; exp_dload = ERRWORD;
    end
    check("hit_cycle", hit_cyc, exp_en + 1);
    check("en_cycles", en_cnt, exp_en);
    check("dload", dload, exp_dload);
    check("derr", {31'd0, derr}, {31'd0, exp_derr});
    check("rd_count", {30'd0, rd_count}, exp_rd);
    check("wr_count", {30'd0, wr_count}, exp_wr);
    @(negedge CLK);
    check("no_rehit", {30'd0, dHit, ramREN | ramWEN}, 32'd0);
  endtask

  initial begin
    RST = 1'b1; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0; daddr = 32'h0; dstore = 32'h0;
    ramload = 32'h0; ramstate = RS_FREE;
    repeat (2) @(negedge CLK);
    check("rst_dhit", {31'd0, dHit}, 32'd0);
    check("rst_en", {30'd0, ramREN, ramWEN}, 32'd0);
    check("rst_dload", dload, 32'h0);
    check("rst_derr", {31'd0, derr}, 32'd0);
    check("rst_cnt", {28'd0, rd_count, wr_count}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // minimum-latency read, write with 3 wait states, ACCESS on the timeout cycle
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, K_ACCESS);
    run_txn(1'b0, 1'b1, 32'h0000_0100, 32'hCAFEF00D, 3, K_ACCESS);
    run_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, TIMEOUT - 1, K_ACCESS);
    // illegal requests, RAM error, stuck BUSY timeout, then a good read
    run_txn(1'b1, 1'b1, 32'h0000_0010, 32'h1, 0, K_ACCESS);
    run_txn(1'b1, 1'b0, 32'h0000_0102, 32'h0, 0, K_ACCESS);
    run_txn(1'b0, 1'b1, 32'h0000_0300, 32'h5, 2, K_ERROR);
    run_txn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 0, K_STUCK);
    run_txn(1'b1, 1'b0, 32'h0000_0404, 32'h0, 1, K_ACCESS);

    // reset in the second REQ cycle
    dREN = 1'b1; daddr = 32'h0000_0500; ramstate = RS_BUSY;
    @(negedge CLK);
    @(negedge CLK);
    check("pre_rst_en", {31'd0, ramREN}, 32'd1);
    RST = 1'b1; dREN = 1'b0;
    @(negedge CLK);
    RST = 1'b0; ramstate = RS_ACCESS;
    exp_rd = 0; exp_wr = 0; exp_derr = 1'b0; exp_dload = 32'h0;
    check("rstmid_en", {30'd0, ramREN, ramWEN}, 32'd0);
    check("rstmid_out", {ramaddr | ramstore | dload}, 32'h0);
    check("rstmid_flags", {28'd0, dHit, derr, rd_count | wr_count}, 32'd0);
    repeat (2) begin
      @(negedge CLK);
      check("rstmid_nohit", {30'd0, dHit, ramREN}, 32'd0);
    end
    ramstate = RS_FREE;
    run_txn(1'b1, 1'b0, 32'h0000_0600, 32'h0, 0, K_ACCESS);

    // halt blocks acceptance
    halt = 1'b1; dREN = 1'b1; daddr = 32'h0000_0700;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("halt_idle", {30'd0, dHit, ramREN | ramWEN}, 32'd0);
    end
    halt = 1'b0; dREN = 1'b0;

    // back-to-back reads saturate the 2-bit read counter
    for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b0, 32'h0000_0800 + 32'(i * 4), 32'h0, 0, K_ACCESS);
    check("rd_sat", {30'd0, rd_count}, 32'd3);

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      int r, kind, busy;
      logic ren, wen;
      logic [31:0] addr;
      r = $urandom_range(0, 9);
      ren = (r == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      wen = (r == 0) ? 1'b1 : ~ren;
      addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (r == 1) addr[1:0] = 2'($urandom_range(1, 3));
      kind = ($urandom_range(0, 7) == 0) ? K_ERROR : K_ACCESS;
      busy = ($urandom_range(0, 9) == 0) ? int'(TIMEOUT) + 1 : $urandom_range(0, 4);
      run_txn(ren, wen, addr, $urandom, busy, kind);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
